// File: rtl/sobel_hls_deadlock_arbiter.sv
// Deadlock arbiter: qualifies monitor block flags, picks a culprit round-robin.
// Optional cycle stamp: define SOBEL_HLS_DEADLOCK_TIMESTAMP_EN.
module sobel_hls_deadlock_arbiter #(
  parameter int NUM_MON = 4,
  parameter int CNT_W   = 16,
  parameter int THRESH  = 1024
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_enable,
  input  logic [NUM_MON-1:0]         i_mon_block,
  input  logic [NUM_MON-1:0]         i_inst_idle,
  output logic                       o_deadlock_valid,
  input  logic                       i_deadlock_ready,
  output logic [$clog2(NUM_MON)-1:0] o_deadlock_idx,
  output logic [NUM_MON-1:0]         o_deadlock_mask,
  output logic [31:0]                o_deadlock_time,
  output logic                       o_busy
);

  localparam int IDX_W = $clog2(NUM_MON);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WATCH,
    S_SCAN,
    S_REPORT,
    S_HOLD
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [NUM_MON-1:0] r_block;
  logic [NUM_MON-1:0] r_idle;
  logic [NUM_MON-1:0] r_prev;
  logic [NUM_MON-1:0] r_mask;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_rr;
  logic [IDX_W-1:0]   r_scan;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_MON-1:0] w_active;
  logic [IDX_W-1:0]   w_scan_nxt;
  logic               w_stable;
  logic               w_trig;
  logic               w_hit;

  assign w_active   = r_block & ~r_idle;
  assign w_stable   = (w_active == r_prev) && (w_active != '0);
  assign w_trig     = w_stable && (r_cnt == CNT_W'(THRESH - 1));
  assign w_hit      = r_mask[r_scan];
  assign w_scan_nxt = (r_scan == IDX_W'(NUM_MON - 1)) ? '0 : r_scan + 1'b1;

  assign o_deadlock_valid = (r_state == S_REPORT);
  assign o_busy           = (r_state != S_IDLE);
  assign o_deadlock_idx   = r_idx;
  assign o_deadlock_mask  = r_mask;

  // Register the monitor flags once before any decision uses them.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_block <= '0;
      r_idle  <= '0;
    end else begin
      r_block <= i_mon_block;
      r_idle  <= i_inst_idle;
    end
  end

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  // Next-state decode; a started report always completes its handshake.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_enable) w_next = S_WATCH;
      end
      S_WATCH: begin
        if (!i_enable)   w_next = S_IDLE;
        else if (w_trig) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (!i_enable)  w_next = S_IDLE;
        else if (w_hit) w_next = S_REPORT;
      end
      S_REPORT: begin
        if (i_deadlock_ready) w_next = i_enable ? S_HOLD : S_IDLE;
      end
      S_HOLD: begin
        if (!i_enable)             w_next = S_IDLE;
        else if (w_active == '0)   w_next = S_WATCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Persistence counter, latched report fields and round-robin pointer.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt  <= '0;
      r_prev <= '0;
      r_mask <= '0;
      r_rr   <= '0;
      r_scan <= '0;
      r_idx  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_cnt  <= '0;
          r_prev <= '0;
        end
        S_WATCH: begin
          if (!i_enable) begin
            r_cnt  <= '0;
            r_prev <= '0;
          end else begin
            r_prev <= w_active;
            if (!w_stable)  r_cnt <= '0;
            else if (~&r_cnt) r_cnt <= r_cnt + 1'b1;
            if (w_trig) begin
              r_mask <= w_active;
              r_scan <= r_rr;
            end
          end
        end
        S_SCAN: begin
          if (!i_enable) begin
            r_cnt  <= '0;
            r_prev <= '0;
          end else if (w_hit) begin
            r_idx <= r_scan;
            r_rr  <= w_scan_nxt;
          end else begin
            r_scan <= w_scan_nxt;
          end
        end
        S_REPORT: begin
          r_cnt <= r_cnt;
        end
        S_HOLD: begin
          if (!i_enable) begin
            r_cnt  <= '0;
            r_prev <= '0;
          end else begin
            r_prev <= w_active;
            if (w_active == '0) r_cnt <= '0;
          end
        end
        default: begin
          r_cnt  <= '0;
          r_prev <= '0;
        end
      endcase
    end
  end

`ifdef SOBEL_HLS_DEADLOCK_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_time;

  // Free-running cycle count, stamped when the blocked mask is latched.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cycle <= '0;
      r_time  <= '0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      if ((r_state == S_WATCH) && i_enable && w_trig) r_time <= r_cycle;
    end
  end

  assign o_deadlock_time = r_time;
`else
  assign o_deadlock_time = 32'd0;
`endif

endmodule
